// File: rtl/mem_port_arbiter_if.sv
// Generic memory bus carrying either a request (DReq) or a response (DResp).
// A request instance uses valid/addr/wen/wdata/wmask/ready; a response instance uses valid/addr/rdata/error/errty.
interface mem_port_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        error;
    logic [1:0]  errty;

    modport req_master (
        output valid, addr, wen, wdata, wmask,
        input  ready
    );
    modport req_slave (
        input  valid, addr, wen, wdata, wmask,
        output ready
    );
    modport resp_master (
        output valid, addr, rdata, error, errty
    );
    modport resp_slave (
        input  valid, addr, rdata, error, errty
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: ifetch (port 0) and data/MMIO (port 1).
// One outstanding transaction; optional response timeout with access-fault return.
module mem_port_arbiter #(
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_port_arbiter_if.req_slave   ireq,
    mem_port_arbiter_if.resp_master iresp,
    mem_port_arbiter_if.req_slave   dreq,
    mem_port_arbiter_if.resp_master dresp,
    mem_port_arbiter_if.req_master  memreq,
    mem_port_arbiter_if.resp_slave  memresp,
    output logic                   grant,
    output logic                   busy
);

    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [1:0] FE_ACCESS_FAULT = 2'd1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_READY,
        WAIT_VALID,
        DRAIN
    } state_t;

    state_t      state, state_nx;
    logic        last_grant;
    logic [CW-1:0] cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_wen;
    logic [3:0]  lat_wmask;

    logic        pick;
    logic        accept;
    logic        mem_valid;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [1:0]  resp_errty;
    logic        timeout_hit;

    always_comb begin
        pick = dreq.valid;
        if (ireq.valid && dreq.valid)
            pick = ROUND_ROBIN ? ~last_grant : 1'b0;
    end

    assign accept      = (state == IDLE) && (ireq.valid || dreq.valid);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

    // Ready is masked during reset so all handshake outputs drop immediately.
    assign ireq.ready = accept && !pick && !reset;
    assign dreq.ready = accept &&  pick && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        mem_valid  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_error = 1'b0;
        resp_errty = '0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = WAIT_READY;
            end
            WAIT_READY: begin
                mem_valid = 1'b1;
                if (memreq.ready) state_nx = WAIT_VALID;
            end
            WAIT_VALID: begin
                if (memresp.valid) begin
                    resp_valid = 1'b1;
                    resp_rdata = memresp.rdata;
                    resp_error = memresp.error;
                    resp_errty = memresp.errty;
                    state_nx   = IDLE;
                end else if (timeout_hit) begin
                    resp_valid = 1'b1;
                    resp_error = 1'b1;
                    resp_errty = FE_ACCESS_FAULT;
                    state_nx   = DRAIN;
                end
            end
            DRAIN: begin
                if (memresp.valid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wen    <= 1'b0;
            lat_wmask  <= '0;
        end else begin
            if (accept) begin
                grant      <= pick;
                last_grant <= pick;
                lat_addr   <= pick ? dreq.addr  : ireq.addr;
                lat_wdata  <= pick ? dreq.wdata : ireq.wdata;
                lat_wen    <= pick ? dreq.wen   : ireq.wen;
                lat_wmask  <= pick ? dreq.wmask : ireq.wmask;
            end
            // Counter saturates rather than wrapping.
            if (state == WAIT_READY && memreq.ready)
                cnt <= '0;
            else if (state == WAIT_VALID && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    assign memreq.valid = mem_valid;
    assign memreq.addr  = lat_addr;
    assign memreq.wen   = lat_wen;
    assign memreq.wdata = lat_wdata;
    assign memreq.wmask = lat_wmask;

    assign iresp.valid = resp_valid && !grant;
    assign iresp.addr  = lat_addr;
    assign iresp.rdata = resp_rdata;
    assign iresp.error = resp_error;
    assign iresp.errty = resp_errty;

    assign dresp.valid = resp_valid && grant;
    assign dresp.addr  = lat_addr;
    assign dresp.rdata = resp_rdata;
    assign dresp.error = resp_error;
    assign dresp.errty = resp_errty;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Instance a: round robin, timeout 8. Instance b: fixed priority, no timeout.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    localparam logic [1:0] FAULT = 2'd1;

    mem_port_arbiter_if a_ireq ();
    mem_port_arbiter_if a_iresp ();
    mem_port_arbiter_if a_dreq ();
    mem_port_arbiter_if a_dresp ();
    mem_port_arbiter_if a_mreq ();
    mem_port_arbiter_if a_mresp ();
    mem_port_arbiter_if b_ireq ();
    mem_port_arbiter_if b_iresp ();
    mem_port_arbiter_if b_dreq ();
    mem_port_arbiter_if b_dresp ();
    mem_port_arbiter_if b_mreq ();
    mem_port_arbiter_if b_mresp ();
    logic a_grant, a_busy, b_grant, b_busy;

    mem_port_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8)) u_a (
        .clk(clk), .reset(reset),
        .ireq(a_ireq), .iresp(a_iresp),
        .dreq(a_dreq), .dresp(a_dresp),
        .memreq(a_mreq), .memresp(a_mresp),
        .grant(a_grant), .busy(a_busy)
    );

    mem_port_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .reset(reset),
        .ireq(b_ireq), .iresp(b_iresp),
        .dreq(b_dreq), .dresp(b_dresp),
        .memreq(b_mreq), .memresp(b_mresp),
        .grant(b_grant), .busy(b_busy)
    );

    task step;
        @(posedge clk);
        #1;
    endtask

    task clear_inputs;
        a_ireq.valid = 0; a_ireq.addr = 0; a_ireq.wen = 0;
        a_ireq.wdata = 0; a_ireq.wmask = 0;
        a_dreq.valid = 0; a_dreq.addr = 0; a_dreq.wen = 0;
        a_dreq.wdata = 0; a_dreq.wmask = 0;
        a_mreq.ready = 0;
        a_mresp.valid = 0; a_mresp.addr = 0; a_mresp.rdata = 0;
        a_mresp.error = 0; a_mresp.errty = 0;
        b_ireq.valid = 0; b_ireq.addr = 0; b_ireq.wen = 0;
        b_ireq.wdata = 0; b_ireq.wmask = 0;
        b_dreq.valid = 0; b_dreq.addr = 0; b_dreq.wen = 0;
        b_dreq.wdata = 0; b_dreq.wmask = 0;
        b_mreq.ready = 0;
        b_mresp.valid = 0; b_mresp.addr = 0; b_mresp.rdata = 0;
        b_mresp.error = 0; b_mresp.errty = 0;
    endtask

    task test_reset;
        clear_inputs();
        reset = 1;
        a_ireq.valid = 1;
        b_dreq.valid = 1;
        #2;
        tests++;
        if ({a_ireq.ready, a_dreq.ready, b_dreq.ready} !== 3'b000) begin
            fails++;
            $display("FAIL rst_ready got %b want 000",
                     {a_ireq.ready, a_dreq.ready, b_dreq.ready});
        end
        tests++;
        if ({a_busy, a_grant, a_mreq.valid, a_iresp.valid, a_dresp.valid} !== 5'b0) begin
            fails++;
            $display("FAIL rst_outs got %b want 00000",
                     {a_busy, a_grant, a_mreq.valid, a_iresp.valid, a_dresp.valid});
        end
        a_ireq.valid = 0;
        b_dreq.valid = 0;
        step();
        step();
        reset = 0;
        step();
    endtask

    // Both ports request continuously; a alternates, b always picks port 0.
    task test_round_robin;
        logic e;
        a_ireq.valid = 1; a_ireq.addr = 32'h100;
        a_dreq.valid = 1; a_dreq.addr = 32'h200;
        b_ireq.valid = 1; b_ireq.addr = 32'h100;
        b_dreq.valid = 1; b_dreq.addr = 32'h200;
        #1;
        for (int k = 0; k < 4; k++) begin
            e = k[0];
            tests++;
            if ({a_ireq.ready, a_dreq.ready} !== {~e, e}) begin
                fails++;
                $display("FAIL rr_ready[%0d] got %b want %b", k,
                         {a_ireq.ready, a_dreq.ready}, {~e, e});
            end
            tests++;
            if ({b_ireq.ready, b_dreq.ready} !== 2'b10) begin
                fails++;
                $display("FAIL fp_ready[%0d] got %b want 10", k,
                         {b_ireq.ready, b_dreq.ready});
            end
            step();
            tests++;
            if ({a_grant, b_grant, a_ireq.ready, a_dreq.ready} !== {e, 3'b000}) begin
                fails++;
                $display("FAIL rr_grant[%0d] got %b want %b", k,
                         {a_grant, b_grant, a_ireq.ready, a_dreq.ready}, {e, 3'b000});
            end
            a_mreq.ready = 1; b_mreq.ready = 1;
            step();
            a_mreq.ready = 0; b_mreq.ready = 0;
            a_mresp.valid = 1; a_mresp.rdata = k;
            b_mresp.valid = 1; b_mresp.rdata = k;
            #1;
            tests++;
            if ({a_iresp.valid, a_dresp.valid} !== {~e, e}) begin
                fails++;
                $display("FAIL rr_resp[%0d] got %b want %b", k,
                         {a_iresp.valid, a_dresp.valid}, {~e, e});
            end
            tests++;
            if ({b_iresp.valid, b_dresp.valid} !== 2'b10) begin
                fails++;
                $display("FAIL fp_resp[%0d] got %b want 10", k,
                         {b_iresp.valid, b_dresp.valid});
            end
            step();
            a_mresp.valid = 0; b_mresp.valid = 0;
            #1;
        end
        a_ireq.valid = 0; a_dreq.valid = 0;
        b_ireq.valid = 0; b_dreq.valid = 0;
        step();
    endtask

    task test_single_read;
        a_ireq.valid = 1; a_ireq.addr = 32'h1000; a_ireq.wen = 0;
        #1;
        tests++;
        if (a_ireq.ready !== 1'b1) begin
            fails++;
            $display("FAIL rd_ready got %b want 1", a_ireq.ready);
        end
        step();
        a_ireq.valid = 0;
        #1;
        tests++;
        if ({a_mreq.valid, a_mreq.addr, a_mreq.wen} !== {1'b1, 32'h1000, 1'b0}) begin
            fails++;
            $display("FAIL rd_memreq got %h want %h",
                     {a_mreq.valid, a_mreq.addr, a_mreq.wen}, {1'b1, 32'h1000, 1'b0});
        end
        a_mreq.ready = 1;
        step();
        a_mreq.ready = 0;
        #1;
        tests++;
        if (a_mreq.valid !== 1'b0) begin
            fails++;
            $display("FAIL rd_memreq_drop got %b want 0", a_mreq.valid);
        end
        step();
        a_mresp.valid = 1; a_mresp.rdata = 32'hDEADBEEF;
        #1;
        tests++;
        if ({a_iresp.valid, a_iresp.rdata, a_iresp.addr, a_dresp.valid, a_grant}
            !== {1'b1, 32'hDEADBEEF, 32'h1000, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL rd_resp got %h want %h",
                     {a_iresp.valid, a_iresp.rdata, a_iresp.addr, a_dresp.valid, a_grant},
                     {1'b1, 32'hDEADBEEF, 32'h1000, 1'b0, 1'b0});
        end
        step();
        a_mresp.valid = 0;
        #1;
        tests++;
        if ({a_iresp.valid, a_busy} !== 2'b00) begin
            fails++;
            $display("FAIL rd_pulse got %b want 00", {a_iresp.valid, a_busy});
        end
    endtask

    task test_write_stall;
        a_dreq.valid = 1; a_dreq.addr = 32'h2004; a_dreq.wen = 1;
        a_dreq.wdata = 32'h0055AA11; a_dreq.wmask = 4'h3;
        #1;
        tests++;
        if (a_dreq.ready !== 1'b1) begin
            fails++;
            $display("FAIL wr_ready got %b want 1", a_dreq.ready);
        end
        step();
        // Requester is free to change its fields once accepted.
        a_dreq.valid = 0; a_dreq.addr = 32'hFFFF_FFFF;
        a_dreq.wdata = 0; a_dreq.wmask = 0; a_dreq.wen = 0;
        #1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({a_mreq.valid, a_mreq.addr, a_mreq.wen, a_mreq.wdata, a_mreq.wmask}
                !== {1'b1, 32'h2004, 1'b1, 32'h0055AA11, 4'h3}) begin
                fails++;
                $display("FAIL wr_hold[%0d] got %h want %h", i,
                         {a_mreq.valid, a_mreq.addr, a_mreq.wen, a_mreq.wdata, a_mreq.wmask},
                         {1'b1, 32'h2004, 1'b1, 32'h0055AA11, 4'h3});
            end
            tests++;
            if ({a_busy, a_dresp.valid, a_iresp.valid} !== 3'b100) begin
                fails++;
                $display("FAIL wr_busy[%0d] got %b want 100", i,
                         {a_busy, a_dresp.valid, a_iresp.valid});
            end
            step();
        end
        a_mreq.ready = 1;
        step();
        a_mreq.ready = 0;
        #1;
        tests++;
        if ({a_mreq.valid, a_dresp.valid, a_busy} !== 3'b001) begin
            fails++;
            $display("FAIL wr_wait got %b want 001",
                     {a_mreq.valid, a_dresp.valid, a_busy});
        end
        step();
        a_mresp.valid = 1; a_mresp.rdata = 0;
        #1;
        tests++;
        if ({a_dresp.valid, a_iresp.valid, a_grant} !== 3'b101) begin
            fails++;
            $display("FAIL wr_resp got %b want 101",
                     {a_dresp.valid, a_iresp.valid, a_grant});
        end
        step();
        a_mresp.valid = 0;
        #1;
    endtask

    task test_timeout;
        a_dreq.valid = 1; a_dreq.addr = 32'h3000; a_dreq.wen = 0;
        #1;
        step();
        a_dreq.valid = 0;
        a_mreq.ready = 1;
        step();
        a_mreq.ready = 0;
        #1;
        for (int c = 1; c < 8; c++) begin
            tests++;
            if ({a_dresp.valid, a_iresp.valid} !== 2'b00) begin
                fails++;
                $display("FAIL to_early[%0d] got %b want 00", c,
                         {a_dresp.valid, a_iresp.valid});
            end
            step();
        end
        tests++;
        if ({a_dresp.valid, a_dresp.error, a_dresp.errty, a_dresp.rdata,
             a_dresp.addr, a_iresp.valid}
            !== {1'b1, 1'b1, FAULT, 32'h0, 32'h3000, 1'b0}) begin
            fails++;
            $display("FAIL to_fault got %h want %h",
                     {a_dresp.valid, a_dresp.error, a_dresp.errty, a_dresp.rdata,
                      a_dresp.addr, a_iresp.valid},
                     {1'b1, 1'b1, FAULT, 32'h0, 32'h3000, 1'b0});
        end
        step();
        a_ireq.valid = 1; a_ireq.addr = 32'h4000;
        #1;
        tests++;
        if ({a_busy, a_ireq.ready, a_dresp.valid} !== 3'b100) begin
            fails++;
            $display("FAIL to_drain got %b want 100",
                     {a_busy, a_ireq.ready, a_dresp.valid});
        end
        step();
        step();
        a_mresp.valid = 1; a_mresp.rdata = 32'hBAD;
        #1;
        tests++;
        if ({a_iresp.valid, a_dresp.valid, a_ireq.ready} !== 3'b000) begin
            fails++;
            $display("FAIL to_swallow got %b want 000",
                     {a_iresp.valid, a_dresp.valid, a_ireq.ready});
        end
        step();
        a_mresp.valid = 0;
        #1;
        tests++;
        if (a_ireq.ready !== 1'b1) begin
            fails++;
            $display("FAIL to_next_ready got %b want 1", a_ireq.ready);
        end
        step();
        a_ireq.valid = 0;
        a_mreq.ready = 1;
        step();
        a_mreq.ready = 0;
        a_mresp.valid = 1; a_mresp.rdata = 32'h4444;
        #1;
        tests++;
        if ({a_iresp.valid, a_iresp.rdata, a_iresp.addr, a_grant}
            !== {1'b1, 32'h4444, 32'h4000, 1'b0}) begin
            fails++;
            $display("FAIL to_next_resp got %h want %h",
                     {a_iresp.valid, a_iresp.rdata, a_iresp.addr, a_grant},
                     {1'b1, 32'h4444, 32'h4000, 1'b0});
        end
        step();
        a_mresp.valid = 0;
        #1;
    endtask

    task test_limit_response;
        a_dreq.valid = 1; a_dreq.addr = 32'h5000;
        #1;
        step();
        a_dreq.valid = 0;
        a_mreq.ready = 1;
        step();
        a_mreq.ready = 0;
        for (int c = 1; c < 8; c++) step();
        a_mresp.valid = 1; a_mresp.rdata = 32'hCAFEF00D;
        a_mresp.error = 1; a_mresp.errty = 2'd2;
        #1;
        tests++;
        if ({a_dresp.valid, a_dresp.rdata, a_dresp.error, a_dresp.errty}
            !== {1'b1, 32'hCAFEF00D, 1'b1, 2'd2}) begin
            fails++;
            $display("FAIL lim_resp got %h want %h",
                     {a_dresp.valid, a_dresp.rdata, a_dresp.error, a_dresp.errty},
                     {1'b1, 32'hCAFEF00D, 1'b1, 2'd2});
        end
        step();
        a_mresp.valid = 0; a_mresp.error = 0; a_mresp.errty = 0;
        #1;
        tests++;
        if (a_busy !== 1'b0) begin
            fails++;
            $display("FAIL lim_no_drain got %b want 0", a_busy);
        end
    endtask

    task test_reset_mid;
        a_ireq.valid = 1; a_ireq.addr = 32'h6000;
        #1;
        step();
        a_ireq.valid = 0;
        a_mreq.ready = 1;
        step();
        a_mreq.ready = 0;
        a_mresp.valid = 1; a_mresp.rdata = 32'h77;
        reset = 1;
        #1;
        tests++;
        if ({a_iresp.valid, a_dresp.valid, a_mreq.valid, a_busy} !== 4'b0000) begin
            fails++;
            $display("FAIL mid_rst got %b want 0000",
                     {a_iresp.valid, a_dresp.valid, a_mreq.valid, a_busy});
        end
        a_mresp.valid = 0;
        step();
        reset = 0;
        a_ireq.valid = 1; a_ireq.addr = 32'h7000;
        a_dreq.valid = 1; a_dreq.addr = 32'h8000;
        #1;
        tests++;
        if ({a_ireq.ready, a_dreq.ready} !== 2'b10) begin
            fails++;
            $display("FAIL mid_regrant got %b want 10",
                     {a_ireq.ready, a_dreq.ready});
        end
        step();
        a_ireq.valid = 0; a_dreq.valid = 0;
        #1;
        tests++;
        if ({a_grant, a_busy, a_mreq.addr} !== {1'b0, 1'b1, 32'h7000}) begin
            fails++;
            $display("FAIL mid_grant got %h want %h",
                     {a_grant, a_busy, a_mreq.addr}, {1'b0, 1'b1, 32'h7000});
        end
        a_mreq.ready = 1;
        step();
        a_mreq.ready = 0;
        a_mresp.valid = 1; a_mresp.rdata = 32'h99;
        #1;
        tests++;
        if ({a_iresp.valid, a_iresp.rdata} !== {1'b1, 32'h99}) begin
            fails++;
            $display("FAIL mid_resp got %h want %h",
                     {a_iresp.valid, a_iresp.rdata}, {1'b1, 32'h99});
        end
        step();
        a_mresp.valid = 0;
        #1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_stall();
        test_timeout();
        test_limit_response();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
